// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory request
// at a time, holds the returned word for decode and follows jump redirects
// when the held instruction is consumed.
module ysyx_22040759_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fire;
  logic [63:0] redirectAligned;

  // The held instruction is consumed only while it is being presented.
  assign fire            = (state_q == HOLD) && inst_ready;
  // A misaligned jump target is silently rounded down to a word boundary.
  assign redirectAligned = redirect_pc & ~64'd3;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = {pc_q[63:2], 2'b00};
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign pc             = pc_q;

  // Next-state, next-PC and instruction capture; responses and redirects
  // outside their owning state leave everything untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fire) begin
          pc_d    = redirect_valid ? redirectAligned : pc_q + 64'd4;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and held instruction; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

endmodule
